// File: rtl/pipe_stage_pkg.sv
// pipe_stage_pkg
// Shared definitions for the ID/EX skid-buffer stage:
//   - stage_state_e : occupancy-encoded state (EMPTY/ONE/TWO)
//   - default payload and control widths
//   - bit offsets and widths of each field in the ID/EX bundle.
//     The bundle is packed from the LSB upward, with control in the low bits.
package pipe_stage_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } stage_state_e;

   // Field widths of the ID/EX bundle.
   localparam int CTRL_FW   = 8;   // RegWrite, MemtoReg, Branch, MemWrite, MemRead, ALUSrc, ALU_op[1:0]
   localparam int RD_FW     = 5;
   localparam int RS2_FW    = 5;
   localparam int RS1_FW    = 5;
   localparam int FUNCT_FW  = 4;
   localparam int IMM_FW    = 64;
   localparam int RS2D_FW   = 64;
   localparam int RS1D_FW   = 64;
   localparam int PC_FW     = 64;

   // Field offsets (LSB position of each field).
   localparam int CTRL_OFF  = 0;
   localparam int RD_OFF    = CTRL_OFF  + CTRL_FW;
   localparam int RS2_OFF   = RD_OFF    + RD_FW;
   localparam int RS1_OFF   = RS2_OFF   + RS2_FW;
   localparam int FUNCT_OFF = RS1_OFF   + RS1_FW;
   localparam int IMM_OFF   = FUNCT_OFF + FUNCT_FW;
   localparam int RS2D_OFF  = IMM_OFF   + IMM_FW;
   localparam int RS1D_OFF  = RS2D_OFF  + RS2D_FW;
   localparam int PC_OFF    = RS1D_OFF  + RS1D_FW;

   // Default widths: the full bundle is 283 bits.
   localparam int PIPE_PAYLOAD_W_DEF = PC_OFF + PC_FW;
   localparam int PIPE_CTRL_W_DEF    = CTRL_FW;

endpackage

// File: rtl/pipe_stage_stats.sv
// pipe_stage_stats
// Saturating 16-bit event counters for the skid stage.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   stall_i         : downstream stall this cycle (valid held, not consumed)
//   flush_hit_i     : flush while the stage held at least one entry
//   stall_cnt_o     : stall cycles counted, sticks at 16'hFFFF
//   flush_cnt_o     : effective flushes counted, sticks at 16'hFFFF
module pipe_stage_stats (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall_i,
   input  logic        flush_hit_i,
   output logic [15:0] stall_cnt_o,
   output logic [15:0] flush_cnt_o
);

   logic [15:0] stall_q, stall_d;
   logic [15:0] flush_q, flush_d;

   always_comb begin
      stall_d = stall_q;
      flush_d = flush_q;
      if (stall_i && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
      if (flush_hit_i && (flush_q != 16'hFFFF)) flush_d = flush_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         stall_q <= stall_d;
         flush_q <= flush_d;
      end
   end

   assign stall_cnt_o = stall_q;
   assign flush_cnt_o = flush_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
// Two-entry skid buffer for the ID/EX pipeline register. Upstream readiness is
// a function of registered state only, so out_ready never reaches in_ready
// combinationally.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1; valid, once raised, is held with stable data until that transfer;
// ready may change freely and never depends on the same side's valid.
//
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   flush                 : synchronous discard of all held entries (wins over in_fire)
//   in_valid/in_ready/in_data    : upstream handshake and payload
//   out_valid/out_ready/out_data : downstream handshake and head payload
//   occupancy             : held entries, 0..2
//   dbg_state             : current FSM state
//   stall_cnt, flush_cnt  : present only with PIPE_STAGE_STATS_EN defined
module pipe_stage_skid
   import pipe_stage_pkg::*;
#(
   parameter int PAYLOAD_W = PIPE_PAYLOAD_W_DEF,
   parameter int CTRL_W    = PIPE_CTRL_W_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [PAYLOAD_W-1:0] in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [PAYLOAD_W-1:0] out_data,
   output logic [1:0]           occupancy,
   output stage_state_e         dbg_state
`ifdef PIPE_STAGE_STATS_EN
   ,
   output logic [15:0]          stall_cnt,
   output logic [15:0]          flush_cnt
`endif
);

   stage_state_e         state_q, state_d;
   logic [PAYLOAD_W-1:0] main_q, main_d;
   logic [PAYLOAD_W-1:0] skid_q, skid_d;
   logic                 in_fire, out_fire;

   assign in_ready  = (state_q != ST_TWO);
   assign out_valid = (state_q != ST_EMPTY);
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (in_fire) begin
                  main_d  = in_data;
                  state_d = ST_ONE;
               end
            end
            ST_ONE: begin
               if (in_fire && out_fire) begin
                  main_d = in_data;
               end else if (in_fire) begin
                  skid_d  = in_data;
                  state_d = ST_TWO;
               end else if (out_fire) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_TWO: begin
               if (out_fire) begin
                  main_d  = skid_q;
                  state_d = ST_ONE;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

   // A bubble must not carry live control bits into EX, since main keeps the
   // last payload after it drains.
   always_comb begin
      out_data = main_q;
      if (!out_valid) out_data[CTRL_W-1:0] = '0;
   end

   assign occupancy = state_q;
   assign dbg_state = state_q;

`ifdef PIPE_STAGE_STATS_EN
   pipe_stage_stats u_stats (
      .clk         (clk),
      .rst_n       (rst_n),
      .stall_i     (out_valid & ~out_ready),
      .flush_hit_i (flush & (state_q != ST_EMPTY)),
      .stall_cnt_o (stall_cnt),
      .flush_cnt_o (flush_cnt)
   );
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;
   import pipe_stage_pkg::*;

   localparam int PW = PIPE_PAYLOAD_W_DEF;
   localparam int CW = PIPE_CTRL_W_DEF;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b0;
   logic [PW-1:0] in_data = '0;
   logic          in_ready, out_valid;
   logic [PW-1:0] out_data;
   logic [1:0]    occupancy;
   stage_state_e  dbg_state;
`ifdef PIPE_STAGE_STATS_EN
   logic [15:0]   stall_cnt, flush_cnt;
`endif

   pipe_stage_skid #(.PAYLOAD_W(PW), .CTRL_W(CW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .occupancy (occupancy),
      .dbg_state (dbg_state)
`ifdef PIPE_STAGE_STATS_EN
      ,
      .stall_cnt (stall_cnt),
      .flush_cnt (flush_cnt)
`endif
   );

   int total = 0;
   int bad = 0;
   logic mon_en = 1'b0;

   // Reference model: the stage is a FIFO of at most two payloads.
   logic [PW-1:0] exp_q[$];

   task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_payload(output logic [PW-1:0] p);
      for (int i = 0; i < PW; i++) p[i] = 1'($urandom_range(0, 1));
   endtask

   task automatic send(input logic [PW-1:0] p);
      in_valid = 1'b1;
      in_data  = p;
      tick();
      in_valid = 1'b0;
   endtask

   // ---------------- scoreboard update ----------------
   // Evaluated from the model's own fill level: accept when fewer than two are
   // held, emit when at least one is held and downstream is ready.
   always @(posedge clk or negedge rst_n) begin
      int  n;
      logic can_pop, can_push;
      if (!rst_n || flush) begin
         exp_q.delete();
      end else begin
         n = exp_q.size();
         can_pop  = (n > 0) && out_ready;
         can_push = (n < 2) && in_valid;
         if (can_pop) void'(exp_q.pop_front());
         if (can_push) exp_q.push_back(in_data);
      end
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (rst_n && mon_en) begin
         check("occupancy", PW'(occupancy), PW'(exp_q.size()));
         check("in_ready", PW'(in_ready), PW'(exp_q.size() < 2));
         check("out_valid", PW'(out_valid), PW'(exp_q.size() > 0));
         if (exp_q.size() > 0) check("out_data", out_data, exp_q[0]);
         else check("bubble_ctrl", PW'(out_data[CW-1:0]), '0);
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [PW-1:0] pa, pb, pc, pd;

      // Async reset asserted before any clock edge.
      #1 rst_n = 1'b0;
      #1;
      check("rst_out_valid", PW'(out_valid), '0);
      check("rst_out_data", out_data, '0);
      check("rst_in_ready", PW'(in_ready), PW'(1));
      check("rst_occupancy", PW'(occupancy), '0);
      tick();
      tick();
      rst_n  = 1'b1;
      mon_en = 1'b1;
      tick();

      // Streaming: 1,2,3,4 back to back with downstream always ready.
      out_ready = 1'b1;
      for (int v = 1; v <= 4; v++) begin
         in_valid = 1'b1;
         in_data  = PW'(v);
         tick();
         check("stream_data", out_data, PW'(v));
         check("stream_occ", PW'(occupancy), PW'(1));
         check("stream_ready", PW'(in_ready), PW'(1));
      end
      in_valid = 1'b0;
      tick();
      check("stream_drained", PW'(occupancy), '0);

      // Backpressure: A then B held, then released in order.
      out_ready = 1'b0;
      rand_payload(pa);
      rand_payload(pb);
      send(pa);
      send(pb);
      check("bp_occ2", PW'(occupancy), PW'(2));
      check("bp_not_ready", PW'(in_ready), '0);
      check("bp_head_a", out_data, pa);
      out_ready = 1'b1;
      tick();
      check("bp_head_b", out_data, pb);
      check("bp_ready_back", PW'(in_ready), PW'(1));
      tick();
      check("bp_empty", PW'(occupancy), '0);

      // Flush while full, with a same-cycle input that must be discarded.
      out_ready = 1'b0;
      send(pa);
      send(pb);
      rand_payload(pc);
      flush    = 1'b1;
      in_valid = 1'b1;
      in_data  = pc;
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      check("flush_occ", PW'(occupancy), '0);
      check("flush_valid", PW'(out_valid), '0);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("flush_no_c", PW'(out_valid), '0);
      end

      // Bubble: previous payload carried all-ones control bits.
      rand_payload(pa);
      pa[CW-1:0] = '1;
      send(pa);
      check("bubble_live", out_data, pa);
      tick();
      check("bubble_valid", PW'(out_valid), '0);
      check("bubble_ctrl0", PW'(out_data[CW-1:0]), '0);

      // Asynchronous reset between edges while full.
      out_ready = 1'b0;
      send(pa);
      send(pb);
      #2 rst_n = 1'b0;
      #1;
      check("arst_valid", PW'(out_valid), '0);
      check("arst_data", out_data, '0);
      check("arst_ready", PW'(in_ready), PW'(1));
      check("arst_occ", PW'(occupancy), '0);
      tick();
      rst_n = 1'b1;
      rand_payload(pd);
      out_ready = 1'b1;
      send(pd);
      check("arst_d_valid", PW'(out_valid), PW'(1));
      check("arst_d_data", out_data, pd);
      tick();

`ifdef PIPE_STAGE_STATS_EN
      // Counters: reset, 5 stall cycles, one effective flush.
      rst_n = 1'b0;
      #1;
      check("stats_rst_stall", PW'(stall_cnt), '0);
      check("stats_rst_flush", PW'(flush_cnt), '0);
      tick();
      rst_n = 1'b1;
      out_ready = 1'b0;
      send(pa);
      for (int i = 0; i < 5; i++) tick();
      out_ready = 1'b1;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      out_ready = 1'b0;
      check("stats_stall", PW'(stall_cnt), PW'(5));
      check("stats_flush", PW'(flush_cnt), PW'(1));
      tick();
`endif

      // Randomized traffic against the FIFO model.
      for (int i = 0; i < 2000; i++) begin
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 19) == 0);
         rand_payload(in_data);
         tick();
      end
      in_valid  = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
      tick();
      tick();
      check("final_empty", PW'(occupancy), '0);

      mon_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 Parameter PAYLOAD_W, default 283, SHALL set the payload width (the full ID/EX bundle).
REQ-002 Parameter CTRL_W, default 8, SHALL set how many payload LSBs are control bits (RegWrite, MemtoReg, Branch, MemWrite, MemRead, ALUSrc, ALU_op[1:0]).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 flush  input  1  SHALL be a synchronous discard of all held entries.
REQ-006 in_valid  input  1  SHALL mean upstream presents a payload.
REQ-007 in_ready  output  1  SHALL mean the stage accepts a payload this cycle.
REQ-008 in_data  input  PAYLOAD_W  SHALL carry the upstream payload.
REQ-009 out_valid  output  1  SHALL mean the stage presents a payload downstream.
REQ-010 out_ready  input  1  SHALL mean downstream consumes the payload this cycle.
REQ-011 out_data  output  PAYLOAD_W  SHALL carry the head payload.
REQ-012 occupancy  output  2  SHALL report held entries (0, 1 or 2).

Function
REQ-013 The block SHALL be a 2-entry skid buffer (main + skid registers) with states EMPTY, ONE and TWO.
REQ-014 in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
REQ-015 in_ready SHALL be 1 in EMPTY and ONE and 0 in TWO, derived from registered state only, with no combinational path from out_ready.
REQ-016 out_valid SHALL be 1 in ONE and TWO; out_data SHALL be the main register.
REQ-017 In EMPTY with in_fire, main SHALL load in_data and the state SHALL go to ONE.
REQ-018 In ONE with in_fire and out_fire, main SHALL load in_data and the state SHALL stay ONE.
REQ-019 In ONE with in_fire and no out_fire, skid SHALL load in_data and the state SHALL go to TWO.
REQ-020 In ONE with out_fire only, the state SHALL go to EMPTY.
REQ-021 In TWO with out_fire, main SHALL load skid and the state SHALL go to ONE; otherwise the state SHALL hold.
REQ-022 Latency SHALL be 1 cycle from in_fire to out_valid when the stage is EMPTY.
REQ-023 Ordering SHALL be strict FIFO; no payload SHALL be duplicated or dropped except by flush.
REQ-024 flush SHALL have highest priority: the next state SHALL be EMPTY, and an in_fire in the same cycle SHALL be discarded.
REQ-025 When out_valid = 0, out_data[CTRL_W-1:0] SHALL read 0, so a bubble never writes a register or memory.
REQ-026 occupancy SHALL equal 0, 1 or 2 for EMPTY, ONE or TWO respectively.

Reset
REQ-027 On rst_n low, state SHALL be EMPTY, main and skid 0, out_valid 0, out_data 0, in_ready 1 and occupancy 0, immediately and without waiting for clk.
REQ-028 Reset asserted mid-transfer SHALL discard all held payloads; the first edge after release SHALL behave as EMPTY.

Configuration
REQ-029 With PIPE_STAGE_STATS_EN defined, the block SHALL add output stall_cnt (16 bits) and output flush_cnt (16 bits).
REQ-030 stall_cnt SHALL count cycles with out_valid=1 and out_ready=0, saturating at 16'hFFFF.
REQ-031 flush_cnt SHALL count flush cycles with occupancy>0, saturating at 16'hFFFF.
REQ-032 Both counters SHALL reset to 0.
REQ-033 Without PIPE_STAGE_STATS_EN, these ports and counters SHALL be absent, and behaviour SHALL be otherwise identical.

Structure
REQ-034 Package pipe_stage_pkg SHALL hold the state encoding (EMPTY=2'd0, ONE=2'd1, TWO=2'd2).
REQ-035 pipe_stage_pkg SHALL also hold the ID/EX field offsets and widths (PC 64, rs1/rs2 data 64, imm 64, funct 4, rd/rs1/rs2 5, control 8) and the default PAYLOAD_W/CTRL_W.
REQ-036 The counters SHALL live in one sub-module pipe_stage_stats, instantiated only under PIPE_STAGE_STATS_EN.

Verification
REQ-037 Streaming test: in_data 1,2,3,4 on consecutive cycles with out_ready=1 -> out_data 1,2,3,4 one cycle later each, occupancy 1 throughout, in_ready 1.
REQ-038 Backpressure test: out_ready=0, send A then B -> occupancy 2, in_ready 0; then out_ready=1 -> A, then B, in_ready back to 1 after A leaves.
REQ-039 Flush test: occupancy 2, flush=1 with in_valid=1 and data C -> next cycle occupancy 0, out_valid 0, C never appears at the output.
REQ-040 Bubble test: EMPTY with previous payload control bits 8'hFF -> out_data[7:0]=0 while out_valid=0.
REQ-041 Async reset test: rst_n low between clock edges while occupancy=2 -> outputs reach reset values immediately; after release, data D is accepted and appears 1 cycle later.
REQ-042 Stats test (PIPE_STAGE_STATS_EN): hold out_valid=1 with out_ready=0 for 5 cycles, then flush once -> stall_cnt=5, flush_cnt=1.
